// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32I load/store
// size codes, controller state encoding and the funct3 legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Codes 3/6/7 never exist; unsigned widths exist only for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the CPU view (lane + size) and the 32-bit
// storage word: byte enables and replicated store data going in, selected
// and extended load data coming out, plus the natural-alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_word_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        align_err_o
);

    logic [31:0] rd_shifted;

    assign rd_shifted = rdata_word_i >> {lane_i, 3'b000};

    // Decode size/sign into enables, store-data placement and load extension
    always_comb begin
        be_o        = 4'b0000;
        wdata_o     = 32'h0;
        rdata_o     = 32'h0;
        align_err_o = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (funct3_i == F3_B) ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                             : {24'h0, rd_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                align_err_o = lane_i[0];
                be_o        = 4'b0011 << lane_i;
                wdata_o     = {2{wdata_i[15:0]}};
                rdata_o     = (funct3_i == F3_H) ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                                 : {16'h0, rd_shifted[15:0]};
            end
            F3_W: begin
                align_err_o = (lane_i != 2'b00);
                be_o        = 4'b1111;
                wdata_o     = wdata_i;
                rdata_o     = rdata_word_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32I data memory with a single-outstanding request/response
// handshake. A request is captured in IDLE, waits WAIT_STATES cycles in BUSY,
// commits on the last BUSY edge and is reported by a one-cycle RESP pulse.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int              IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]      CNT_INIT   = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rd_word, wr_word, ld_data;
    logic [3:0]        be;
    logic              align_err, range_err, func_err, acc_err;
    logic              do_access, do_write;

    // Out-of-range addresses never reach storage, so only the in-range index bits matter
    assign word_idx  = addr_q[IDX_W+1:2];
    assign range_err = ({1'b0, addr_q} >= ADDR_LIMIT);
    assign func_err  = f3_illegal(we_q, f3_q);
    assign acc_err   = align_err | range_err | func_err;
    assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign do_write  = rst_ni && do_access && we_q && !acc_err;

    dmem_lane_align u_lane_align (
        .lane_i       (addr_q[1:0]),
        .funct3_i     (f3_q),
        .rdata_word_i (rd_word),
        .wdata_i      (wdata_q),
        .be_o         (be),
        .wdata_o      (wr_word),
        .rdata_o      (ld_data),
        .align_err_o  (align_err)
    );

    // One byte-wide bank per lane so partial stores need no read-modify-write
    for (genvar gi = 0; gi < 4; gi++) begin : gen_bank
        logic [7:0] bank_q [DEPTH_WORDS];

        // Commit the enabled byte of a legal store on the final BUSY edge
        always_ff @(posedge clk_i) begin
            if (do_write && be[gi]) begin
                bank_q[word_idx] <= wr_word[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = bank_q[word_idx];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, count down wait states, pulse the response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE:    req_ready_o = 1'b1;
            RESP:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Request capture, wait counter and response formation
    always_comb begin
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || we_q) ? 32'h0 : ld_data;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; response fields hold until the next response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed RISC-V data memory with a request/response handshake and a programmable wait-state counter.
- Handles all RV32I load/store widths: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Detects misaligned, out-of-range and illegal accesses.
- Sits between the CPU's MEM stage and the word-array storage; the stage stalls on req_ready/rsp_valid.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored.
- ADDR_W, 8, byte-address width; must satisfy 2^ADDR_W >= 4*DEPTH_WORDS.
- WAIT_STATES, 0, extra cycles inserted before each access commits (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  out  1  access rejected (misaligned, out of range, or illegal funct3).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. When rst_n is low at a rising edge:
  - state goes to IDLE;
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - the counter clears.
- Memory array: not reset; contents persist across reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid & req_ready, latch we, funct3, addr and wdata; load cnt=WAIT_STATES; go to BUSY.
  - BUSY: req_ready=0. While cnt!=0, decrement cnt. When cnt==0, at that edge perform the access and register the response; go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; req_ready=0; go to IDLE.
- Latency and throughput:
  - A request accepted in cycle t gives rsp_valid in cycle t+2+WAIT_STATES.
  - req_ready is next high in cycle t+3+WAIT_STATES.
  - One outstanding request; no back-to-back acceptance.
- Request stability: inputs are sampled only at the accept edge. Later changes to inputs are ignored.
- Word index and byte lane: word index = addr[ADDR_W-1:2]; byte lane = addr[1:0].
- Loads (funct3 0/1/2/4/5 = LB/LH/LW/LBU/LHU):
  - Select the byte or halfword at the lane.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores (funct3 0/1/2 = SB/SH/SW):
  - Write only the addressed bytes.
  - The other bytes of the word are unchanged.
- Error conditions; each sets rsp_err=1, rsp_rdata=0 and suppresses any write:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= 4*DEPTH_WORDS;
  - funct3 in {3,6,7};
  - store with funct3 in {4,5}.
- Response fields: rsp_rdata and rsp_err hold their value after RESP until the next response. Only rsp_valid qualifies them.
- Reset mid-operation: rst_n low during BUSY discards the request and no write occurs. rst_n low during RESP drops the pulse.
- Read-after-write: a load following a store to the same word returns the updated data.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - FSM state encoding IDLE/BUSY/RESP as a 2-bit typedef.
- One combinational sub-module, dmem_lane_align:
  - inputs: lane, funct3, read word, store data;
  - outputs: 4-bit byte-enable, shifted write data, extended load data, align_err.
- Top level holds the FSM, the wait counter, range check and storage.

Test Plan:
- Reset then word access, WAIT_STATES=0: SW addr 0x08 data 0xDEADBEEF, then LW 0x08 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
- Byte and half stores, then extended loads:
  - SW 0x10 0x00000000, SB 0x11 0x12345680, SH 0x12 0xFFFF8001, then LW 0x10 -> 0x80018000;
  - LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
- Errors:
  - LW 0x06 -> rsp_err=1, rsp_rdata=0;
  - SH 0x05 -> rsp_err=1 and the word at 0x04 is unchanged;
  - funct3=3 -> rsp_err=1;
  - LW 0x100 with DEPTH_WORDS=64 -> rsp_err=1.
- Wait states, WAIT_STATES=3: accept in cycle t -> rsp_valid in cycle t+5. req_ready is low in cycles t+1..t+5. Changing req_addr during BUSY has no effect.
- Reset mid-operation, WAIT_STATES=3: SW 0x20 0xCAFEF00D, pull rst_n low for one cycle in BUSY -> no rsp_valid, req_ready=1 after reset. A following LW 0x20 returns the prior contents.
